// File: rtl/ula_arbiter_if.sv
// ula_arbiter_if: request/response bundle for the two requesters of ula_arbiter.
// Revision: 1.0
`default_nettype none

interface ula_arbiter_if #(
  parameter int WIDTH = 64
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_s1;
  logic [WIDTH-1:0] req0_s2;
  logic             req0_sub;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_res;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_s1;
  logic [WIDTH-1:0] req1_s2;
  logic             req1_sub;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_res;

  modport slave (
    input  req0_valid, req0_s1, req0_s2, req0_sub, rsp0_ready,
    input  req1_valid, req1_s1, req1_s2, req1_sub, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_res,
    output req1_ready, rsp1_valid, rsp1_res
  );

  modport master (
    output req0_valid, req0_s1, req0_s2, req0_sub, rsp0_ready,
    output req1_valid, req1_s1, req1_s2, req1_sub, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_res,
    input  req1_ready, rsp1_valid, rsp1_res
  );
endinterface

`default_nettype wire

// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin sharing of one add/subtract ula between two requesters,
// each with its own registered result slot. Revision: 1.0
`default_nettype none

module ula #(
  parameter int WIDTH = 64
) (
  input  wire logic [WIDTH-1:0] i_s1,
  input  wire logic [WIDTH-1:0] i_s2,
  input  wire logic             i_sub,
  output logic      [WIDTH-1:0] o_res
);
  assign o_res = i_sub ? (i_s1 - i_s2) : (i_s1 + i_s2);
endmodule

module ula_arbiter #(
  parameter int WIDTH = 64
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  ula_arbiter_if.slave     bus
);
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp0_res;
  logic [WIDTH-1:0] r_rsp1_res;
  logic             r_last_grant;

  logic             w_elig0;
  logic             w_elig1;
  logic             w_grant0;
  logic             w_grant1;
  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_s2;
  logic             w_sub;
  logic [WIDTH-1:0] w_res;

  // A requester holding an unconsumed result sits out arbitration.
  assign w_elig0  = bus.req0_valid & ~r_rsp0_valid;
  assign w_elig1  = bus.req1_valid & ~r_rsp1_valid;
  assign w_grant0 = w_elig0 & (~w_elig1 | r_last_grant);
  assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last_grant);

  always_comb begin
    w_s1  = '0;
    w_s2  = '0;
    w_sub = 1'b0;
    if (w_grant0) begin
      w_s1  = bus.req0_s1;
      w_s2  = bus.req0_s2;
      w_sub = bus.req0_sub;
    end else if (w_grant1) begin
      w_s1  = bus.req1_s1;
      w_s2  = bus.req1_s2;
      w_sub = bus.req1_sub;
    end
  end

  ula #(.WIDTH(WIDTH)) u_ula (
    .i_s1  (w_s1),
    .i_s2  (w_s2),
    .i_sub (w_sub),
    .o_res (w_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_res   <= '0;
      r_rsp1_res   <= '0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_grant0) begin
        r_rsp0_res   <= w_res;
        r_rsp0_valid <= 1'b1;
      end else if (r_rsp0_valid && bus.rsp0_ready) begin
        r_rsp0_valid <= 1'b0;
      end

      if (w_grant1) begin
        r_rsp1_res   <= w_res;
        r_rsp1_valid <= 1'b1;
      end else if (r_rsp1_valid && bus.rsp1_ready) begin
        r_rsp1_valid <= 1'b0;
      end

      if (w_grant0) begin
        r_last_grant <= 1'b0;
      end else if (w_grant1) begin
        r_last_grant <= 1'b1;
      end
    end
  end

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp0_res   = r_rsp0_res;
  assign bus.rsp1_res   = r_rsp1_res;
endmodule

`default_nettype wire

// File: tb/tb_ula_arbiter.sv
// tb_ula_arbiter: directed stimulus with a per-cycle reference model of ula_arbiter.
// Revision: 1.0
`default_nettype none

module tb_ula_arbiter;
  localparam int WIDTH = 64;
  localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ula_arbiter_if #(.WIDTH(WIDTH)) bus ();

  ula_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: one result slot per requester, plus who was served last.
  logic             m_v[2];
  logic [WIDTH-1:0] m_res[2];
  int               m_last;

  initial begin : compare
    logic             rv[2];
    logic             rr[2];
    logic [WIDTH-1:0] a[2];
    logic [WIDTH-1:0] b[2];
    logic             sb[2];
    int               g;
    m_v = '{1'b0, 1'b0};
    m_res = '{'0, '0};
    m_last = 1;
    forever begin
      @(negedge clk);
      #4;
      rv = '{bus.req0_valid, bus.req1_valid};
      rr = '{bus.rsp0_ready, bus.rsp1_ready};
      a  = '{bus.req0_s1, bus.req1_s1};
      b  = '{bus.req0_s2, bus.req1_s2};
      sb = '{bus.req0_sub, bus.req1_sub};
      if (!rst_n) begin
        m_v = '{1'b0, 1'b0};
        m_res = '{'0, '0};
        m_last = 1;
      end
      chk("model rsp0_valid", bus.rsp0_valid, m_v[0]);
      chk("model rsp1_valid", bus.rsp1_valid, m_v[1]);
      chk("model rsp0_res", bus.rsp0_res, m_res[0]);
      chk("model rsp1_res", bus.rsp1_res, m_res[1]);
      if (rst_n) begin
        g = -1;
        if (rv[0] && !m_v[0] && rv[1] && !m_v[1]) g = 1 - m_last;
        else if (rv[0] && !m_v[0])                g = 0;
        else if (rv[1] && !m_v[1])                g = 1;
        chk("model req0_ready", bus.req0_ready, (g == 0));
        chk("model req1_ready", bus.req1_ready, (g == 1));
        for (int i = 0; i < 2; i++) if (m_v[i] && rr[i]) m_v[i] = 1'b0;
        if (g >= 0) begin
          m_v[g]   = 1'b1;
          m_res[g] = sb[g] ? (a[g] - b[g]) : (a[g] + b[g]);
          m_last   = g;
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_s1 = '0; bus.req0_s2 = '0; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_s1 = '0; bus.req1_s2 = '0; bus.req1_sub = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
  endtask

  task automatic set0(input logic v, input logic [WIDTH-1:0] s1,
                      input logic [WIDTH-1:0] s2, input logic sub);
    bus.req0_valid = v; bus.req0_s1 = s1; bus.req0_s2 = s2; bus.req0_sub = sub;
  endtask

  task automatic set1(input logic v, input logic [WIDTH-1:0] s1,
                      input logic [WIDTH-1:0] s2, input logic sub);
    bus.req1_valid = v; bus.req1_s1 = s1; bus.req1_s2 = s2; bus.req1_sub = sub;
  endtask

  initial begin : stim
    int c0;
    int c1;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("reset rsp0_valid", bus.rsp0_valid, 0);
    chk("reset rsp1_res", bus.rsp1_res, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: single add on requester 0
    set0(1, 450, 47, 0);
    #1 chk("t1 req0_ready", bus.req0_ready, 1);
    @(negedge clk); set0(0, 0, 0, 0);
    #1 chk("t1 rsp0_valid", bus.rsp0_valid, 1);
    chk("t1 rsp0_res", bus.rsp0_res, 497);
    chk("t1 rsp1_valid", bus.rsp1_valid, 0);
    @(negedge clk);
    #1 chk("t1 rsp0 drained", bus.rsp0_valid, 0);

    // 2: subtracts on requester 1
    set1(1, 450, 47, 1);
    @(negedge clk); set1(0, 0, 0, 0);
    #1 chk("t2 rsp1_res 403", bus.rsp1_res, 403);
    @(negedge clk); set1(1, 0, 1, 1);
    @(negedge clk); set1(0, 0, 0, 0);
    #1 chk("t2 rsp1_res all ones", bus.rsp1_res, ALL1);
    @(negedge clk);

    // 3: contention with prompt draining
    set0(1, 10, 1, 0);
    set1(1, 20, 5, 1);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i == 0) chk("t3 first grant req0", bus.req0_ready, 1);
      c0 += int'(bus.req0_ready);
      c1 += int'(bus.req1_ready);
      @(negedge clk);
      if (i == 0) chk("t3 rsp0_res 11", bus.rsp0_res, 11);
    end
    chk("t3 req0 accepts", c0, 4);
    chk("t3 req1 accepts", c1, 4);
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // 4: backpressure on requester 0 does not block requester 1
    bus.rsp0_ready = 1'b0;
    set0(1, 7, 8, 0);
    @(negedge clk);
    set0(1, 1, 1, 0);
    set1(1, 5, 5, 0);
    #1 chk("t4 rsp0_res 15", bus.rsp0_res, 15);
    chk("t4 req0 blocked", bus.req0_ready, 0);
    chk("t4 req1 granted", bus.req1_ready, 1);
    @(negedge clk); set1(0, 0, 0, 0);
    #1 chk("t4 rsp1_res 10", bus.rsp1_res, 10);
    chk("t4 rsp0 held", bus.rsp0_valid, 1);
    bus.rsp0_ready = 1'b1;
    #1 chk("t4 req0 still blocked", bus.req0_ready, 0);
    @(negedge clk);
    #1 chk("t4 rsp0 cleared", bus.rsp0_valid, 0);
    chk("t4 req0 regranted", bus.req0_ready, 1);
    @(negedge clk); set0(0, 0, 0, 0);
    #1 chk("t4 rsp0_res 2", bus.rsp0_res, 2);
    @(negedge clk);

    // 5: wrap-around
    set0(1, ALL1, 1, 0);
    @(negedge clk); set0(0, 0, 0, 0);
    #1 chk("t5 wrap rsp0_valid", bus.rsp0_valid, 1);
    chk("t5 wrap rsp0_res", bus.rsp0_res, 0);
    @(negedge clk);

    // 6: asynchronous reset with a pending result
    bus.rsp1_ready = 1'b0;
    set1(1, 3, 4, 0);
    @(negedge clk); set1(0, 0, 0, 0);
    #1 chk("t6 rsp1_res 7", bus.rsp1_res, 7);
    rst_n = 1'b0;
    #1 chk("t6 async rsp1_valid", bus.rsp1_valid, 0);
    chk("t6 async rsp1_res", bus.rsp1_res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp1_ready = 1'b1;
    set0(1, 2, 2, 0);
    set1(1, 9, 9, 0);
    #1 chk("t6 post-reset req0 wins", bus.req0_ready, 1);
    chk("t6 post-reset req1 waits", bus.req1_ready, 0);
    repeat (3) @(negedge clk);
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
